// File: rtl/nonogram_multilane_solver_if.sv
// rtl/nonogram_multilane_solver_if.sv - per-lane option input and push-back streams of the multilane solver
interface nonogram_multilane_solver_if #(
    parameter int NUM_LANES = 2,
    parameter int OPT_W     = 16
);
    logic [NUM_LANES-1:0]       lane_in_valid;
    logic [NUM_LANES-1:0]       lane_in_ready;
    logic [NUM_LANES*OPT_W-1:0] lane_in_data;
    logic [NUM_LANES-1:0]       lane_out_valid;
    logic [NUM_LANES-1:0]       lane_out_ready;
    logic [NUM_LANES*OPT_W-1:0] lane_out_data;

    modport master (
        output lane_in_valid, lane_in_data, lane_out_ready,
        input  lane_in_ready, lane_out_valid, lane_out_data
    );

    modport slave (
        input  lane_in_valid, lane_in_data, lane_out_ready,
        output lane_in_ready, lane_out_valid, lane_out_data
    );
endinterface

// File: rtl/nonogram_multilane_solver.sv
// rtl/nonogram_multilane_solver.sv - multilane line-elimination nonogram solver, round-robin board writes
// Optional feature macro: CONFLICT_CHECK_EN (unsolvable-board detection).
module nonogram_multilane_solver #(
    parameter int  MAX_ROWS        = 11,
    parameter int  MAX_COLS        = 11,
    parameter int  MAX_NUM_OPTIONS = 84,
    parameter int  NUM_LANES       = 2,
    parameter int  OPT_W           = 16,
    localparam int NL              = MAX_ROWS + MAX_COLS,
    localparam int CNT_W           = $clog2(MAX_NUM_OPTIONS + 1),
    localparam int RW              = $clog2(MAX_ROWS + 1),
    localparam int CW              = $clog2(MAX_COLS + 1),
    localparam int NCELL           = MAX_ROWS * MAX_COLS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [RW-1:0]             num_rows,
    input  logic [CW-1:0]             num_cols,
    input  logic [NL*CNT_W-1:0]       init_counts,
    nonogram_multilane_solver_if.slave lanes,
    output logic [NCELL-1:0]          assigned,
    output logic [NCELL-1:0]          known,
    output logic                      busy,
    output logic                      solved,
    output logic                      unsolvable
);
    localparam int IW = (NL > 1) ? $clog2(NL) : 1;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} g_state_t;
    typedef enum logic [1:0] {L_IDLE, L_HEADER, L_SCAN, L_WAIT_WR} l_state_t;

    g_state_t         g_q;
    l_state_t         ls_q   [NUM_LANES];
    logic [IW-1:0]    idx_q  [NUM_LANES];
    logic [CNT_W-1:0] rem_q  [NUM_LANES];
    logic [CNT_W-1:0] vcnt_q [NUM_LANES];
    logic [OPT_W-1:0] a1_q   [NUM_LANES];
    logic [OPT_W-1:0] a0_q   [NUM_LANES];
    logic [OPT_W-1:0] od_q   [NUM_LANES];
    logic [NUM_LANES-1:0] ov_q;
    logic [CNT_W-1:0] cnt_q  [NL];
    logic [LW-1:0]    rr_q;
    logic [NCELL-1:0] known_q, assigned_q;
    logic             busy_q, solved_q, unsolv_q;

    int nr, nc;
    assign nr = int'(num_rows);
    assign nc = int'(num_cols);

    // Gather line li from a row-major board; column lines are read transposed.
    function automatic logic [OPT_W-1:0] line_get(input int li, input int r_n, input int c_n,
                                                  input logic [NCELL-1:0] b);
        logic [OPT_W-1:0] v;
        v = '0;
        for (int r = 0; r < MAX_ROWS; r++)
            for (int c = 0; c < MAX_COLS; c++)
                if (li < r_n) begin
                    if (r == li && c < c_n) v[c] = b[r*MAX_COLS+c];
                end else if (c == li - r_n && c < c_n && r < r_n) begin
                    v[r] = b[r*MAX_COLS+c];
                end
        return v;
    endfunction

    function automatic logic [NCELL-1:0] line_put(input int li, input int r_n, input int c_n,
                                                  input logic [OPT_W-1:0] v);
        logic [NCELL-1:0] b;
        b = '0;
        for (int r = 0; r < MAX_ROWS; r++)
            for (int c = 0; c < MAX_COLS; c++)
                if (li < r_n) begin
                    if (r == li && c < c_n) b[r*MAX_COLS+c] = v[c];
                end else if (c == li - r_n && c < c_n && r < r_n) begin
                    b[r*MAX_COLS+c] = v[r];
                end
        return b;
    endfunction

    logic [OPT_W-1:0]           in_d [NUM_LANES];
    logic [NUM_LANES-1:0]       cons, acc, in_rdy, req;
    logic [NUM_LANES*OPT_W-1:0] od_flat;
    logic [NCELL-1:0]           act;
    logic                       all_known;

    always_comb begin
        od_flat = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            in_d[l] = lanes.lane_in_data[l*OPT_W +: OPT_W];
            cons[l] = (((in_d[l] ^ line_get(int'(idx_q[l]), nr, nc, assigned_q))
                        & line_get(int'(idx_q[l]), nr, nc, known_q)
                        & line_get(int'(idx_q[l]), nr, nc, '1)) == '0);
            in_rdy[l] = (ls_q[l] == L_HEADER) ||
                        (ls_q[l] == L_SCAN && (lanes.lane_out_ready[l] || !ov_q[l]));
            acc[l] = in_rdy[l] && lanes.lane_in_valid[l];
            req[l] = (ls_q[l] == L_WAIT_WR);
            od_flat[l*OPT_W +: OPT_W] = od_q[l];
        end
        act = '0;
        for (int r = 0; r < MAX_ROWS; r++)
            for (int c = 0; c < MAX_COLS; c++)
                act[r*MAX_COLS+c] = (r < nr) && (c < nc);
        all_known = ((act & ~known_q) == '0);
    end

    // Round-robin: lowest offset from rr_q wins, so iterate downwards and let the last hit stand.
    logic          gnt_v;
    logic [LW-1:0] gnt_l;
    always_comb begin
        gnt_v = 1'b0;
        gnt_l = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (req[(int'(rr_q) + k) % NUM_LANES]) begin
                gnt_v = 1'b1;
                gnt_l = LW'((int'(rr_q) + k) % NUM_LANES);
            end
        end
    end

    logic [OPT_W-1:0] g_a1, g_a0, g_mask;
    logic [NCELL-1:0] wr_mask, wr_val;
    logic             conflict;
    always_comb begin
        g_a1    = a1_q[gnt_l];
        g_a0    = a0_q[gnt_l];
        g_mask  = line_get(int'(idx_q[gnt_l]), nr, nc, '1);
        wr_mask = line_put(int'(idx_q[gnt_l]), nr, nc, (g_a1 | g_a0) & g_mask);
        wr_val  = line_put(int'(idx_q[gnt_l]), nr, nc, g_a1);
`ifdef CONFLICT_CHECK_EN
        // Only lanes with a nonzero count ever reach the write request, so vcount==0 alone flags it.
        conflict = gnt_v && ((vcnt_q[gnt_l] == '0) || ((g_a1 & g_a0 & g_mask) != '0) ||
                             ((wr_mask & known_q & (wr_val ^ assigned_q)) != '0));
`else
        conflict = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q        <= G_IDLE;
            busy_q     <= 1'b0;
            solved_q   <= 1'b0;
            unsolv_q   <= 1'b0;
            known_q    <= '0;
            assigned_q <= '0;
            rr_q       <= '0;
            ov_q       <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                ls_q[l]   <= L_IDLE;
                idx_q[l]  <= '0;
                rem_q[l]  <= '0;
                vcnt_q[l] <= '0;
                a1_q[l]   <= '0;
                a0_q[l]   <= '0;
                od_q[l]   <= '0;
            end
            for (int i = 0; i < NL; i++) cnt_q[i] <= '0;
        end else if (start) begin
            g_q        <= G_RUN;
            busy_q     <= 1'b1;
            solved_q   <= 1'b0;
            unsolv_q   <= 1'b0;
            known_q    <= '0;
            assigned_q <= '0;
            rr_q       <= '0;
            ov_q       <= '0;
            for (int l = 0; l < NUM_LANES; l++) ls_q[l] <= L_HEADER;
            for (int i = 0; i < NL; i++) cnt_q[i] <= init_counts[i*CNT_W +: CNT_W];
        end else if (g_q == G_RUN) begin
            if (all_known || conflict) begin
                g_q      <= G_DONE;
                busy_q   <= 1'b0;
                solved_q <= all_known;
                unsolv_q <= !all_known;
                ov_q     <= '0;
                for (int l = 0; l < NUM_LANES; l++) ls_q[l] <= L_IDLE;
            end else begin
                if (gnt_v) begin
                    known_q             <= known_q | wr_mask;
                    assigned_q          <= (assigned_q & ~wr_mask) | (wr_val & wr_mask);
                    cnt_q[idx_q[gnt_l]] <= vcnt_q[gnt_l];
                    rr_q                <= (int'(gnt_l) == NUM_LANES - 1) ? '0 : gnt_l + 1'b1;
                end
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (ov_q[l] && lanes.lane_out_ready[l]) ov_q[l] <= 1'b0;
                    case (ls_q[l])
                        L_HEADER: begin
                            if (lanes.lane_in_valid[l] && int'(in_d[l]) < nr + nc) begin
                                idx_q[l]  <= in_d[l][IW-1:0];
                                rem_q[l]  <= cnt_q[in_d[l][IW-1:0]];
                                vcnt_q[l] <= '0;
                                a1_q[l]   <= '1;
                                a0_q[l]   <= '1;
                                if (cnt_q[in_d[l][IW-1:0]] != '0) ls_q[l] <= L_SCAN;
                            end
                        end
                        L_SCAN: begin
                            if (acc[l]) begin
                                rem_q[l] <= rem_q[l] - 1'b1;
                                if (cons[l]) begin
                                    od_q[l]   <= in_d[l];
                                    ov_q[l]   <= 1'b1;
                                    a1_q[l]   <= a1_q[l] & in_d[l];
                                    a0_q[l]   <= a0_q[l] & ~in_d[l];
                                    vcnt_q[l] <= vcnt_q[l] + 1'b1;
                                end
                                if (rem_q[l] == CNT_W'(1)) ls_q[l] <= L_WAIT_WR;
                            end
                        end
                        L_WAIT_WR: begin
                            if (gnt_v && int'(gnt_l) == l) ls_q[l] <= L_HEADER;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign lanes.lane_in_ready  = in_rdy;
    assign lanes.lane_out_valid = ov_q;
    assign lanes.lane_out_data  = od_flat;
    assign assigned             = assigned_q;
    assign known                = known_q;
    assign busy                 = busy_q;
    assign solved               = solved_q;
    assign unsolvable           = unsolv_q;
endmodule

// File: tb/tb_nonogram_multilane_solver.sv
// tb/tb_nonogram_multilane_solver.sv - directed self-checking bench for nonogram_multilane_solver
module tb_nonogram_multilane_solver;
    localparam int MC = 11, CNT_W = 7, NL = 22, OW = 16, NCELL = 121;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [3:0]          num_rows, num_cols;
    logic [NL*CNT_W-1:0] init_counts;
    logic [NCELL-1:0]    assigned, known;
    logic                busy, solved, unsolvable;
    int                  n_chk = 0;
    int                  n_fail = 0;
    logic [127:0]        kexp, aexp;

    nonogram_multilane_solver_if #(.NUM_LANES(2), .OPT_W(OW)) lif ();

    nonogram_multilane_solver dut (
        .clk(clk), .rst(rst), .start(start),
        .num_rows(num_rows), .num_cols(num_cols), .init_counts(init_counts),
        .lanes(lif.slave),
        .assigned(assigned), .known(known),
        .busy(busy), .solved(solved), .unsolvable(unsolvable)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] cb(input int r, input int c);
        return 128'(1) << (r * MC + c);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int l, input logic v, input logic [OW-1:0] d);
        lif.lane_in_valid[l]          = v;
        lif.lane_in_data[l*OW +: OW]  = d;
    endtask

    task automatic set_cnt(input int line, input int v);
        init_counts[line*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        lif.lane_in_valid  = '0;
        lif.lane_in_data   = '0;
        lif.lane_out_ready = 2'b11;
        num_rows    = 4'd1;
        num_cols    = 4'd1;
        init_counts = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_busy",   128'(busy), 128'(0));
        chk("rst_solved", 128'(solved), 128'(0));
        chk("rst_unsolv", 128'(unsolvable), 128'(0));
        chk("rst_known",  128'(known), 128'(0));
        chk("rst_assign", 128'(assigned), 128'(0));
        chk("rst_inrdy",  128'(lif.lane_in_ready), 128'(0));
        chk("rst_ovalid", 128'(lif.lane_out_valid), 128'(0));

        // 1x1 board
        set_cnt(0, 1);
        set_cnt(1, 1);
        do_start();
        chk("t1_busy",  128'(busy), 128'(1));
        chk("t1_inrdy", 128'(lif.lane_in_ready), 128'(2'b11));
        drv(0, 1'b1, 16'd0);
        cyc();
        drv(0, 1'b1, 16'h1);
        cyc();
        chk("t1_ovalid", 128'(lif.lane_out_valid[0]), 128'(1));
        chk("t1_odata",  128'(lif.lane_out_data[15:0]), 128'(1));
        chk("t1_wait_inrdy", 128'(lif.lane_in_ready[0]), 128'(0));
        drv(0, 1'b0, 16'd0);
        cyc();
        chk("t1_known",  128'(known), cb(0, 0));
        chk("t1_assign", 128'(assigned), cb(0, 0));
        chk("t1_solved_early", 128'(solved), 128'(0));
        cyc();
        chk("t1_solved", 128'(solved), 128'(1));
        chk("t1_busy_done", 128'(busy), 128'(0));
        chk("t1_done_inrdy", 128'(lif.lane_in_ready), 128'(0));

        // 3x3, row 1 with options 011 and 110
        num_rows = 4'd3;
        num_cols = 4'd3;
        init_counts = '0;
        set_cnt(1, 2);
        do_start();
        chk("t2_clear_known", 128'(known), 128'(0));
        chk("t2_clear_solved", 128'(solved), 128'(0));
        drv(0, 1'b1, 16'd1);
        cyc();
        drv(0, 1'b1, 16'b011);
        cyc();
        chk("t2_out0", 128'(lif.lane_out_data[15:0]), 128'(3));
        drv(0, 1'b1, 16'b110);
        cyc();
        chk("t2_out1", 128'(lif.lane_out_data[15:0]), 128'(6));
        chk("t2_out1_v", 128'(lif.lane_out_valid[0]), 128'(1));
        drv(0, 1'b0, 16'd0);
        cyc();
        chk("t2_known",  128'(known), cb(1, 1));
        chk("t2_assign", 128'(assigned), cb(1, 1));
        drv(0, 1'b1, 16'd1);
        cyc();
        drv(0, 1'b1, 16'b011);
        cyc();
        drv(0, 1'b0, 16'd0);
        cyc();
        cyc();
        chk("t2_table_cnt2", 128'(known), cb(1, 1));
        drv(0, 1'b1, 16'b110);
        cyc();
        drv(0, 1'b0, 16'd0);
        cyc();
        chk("t2_rewrite_known", 128'(known), cb(1, 1));
        chk("t2_rewrite_inrdy", 128'(lif.lane_in_ready[0]), 128'(1));

        // Arbitration order
        init_counts = '0;
        for (int i = 0; i < 5; i++) set_cnt(i, 1);
        do_start();
        drv(0, 1'b1, 16'd0);
        drv(1, 1'b1, 16'd2);
        cyc();
        drv(0, 1'b1, 16'b001);
        drv(1, 1'b1, 16'b100);
        cyc();
        drv(0, 1'b0, 16'd0);
        drv(1, 1'b0, 16'd0);
        cyc();
        kexp = cb(0, 0) | cb(0, 1) | cb(0, 2);
        aexp = cb(0, 0);
        chk("t3_first_lane0_known", 128'(known), kexp);
        chk("t3_first_lane0_assign", 128'(assigned), aexp);
        cyc();
        kexp = kexp | cb(2, 0) | cb(2, 1) | cb(2, 2);
        aexp = aexp | cb(2, 2);
        chk("t3_second_lane1_known", 128'(known), kexp);
        chk("t3_second_lane1_assign", 128'(assigned), aexp);
        drv(0, 1'b1, 16'd3);
        cyc();
        drv(0, 1'b1, 16'b011);
        cyc();
        drv(0, 1'b0, 16'd0);
        cyc();
        kexp = kexp | cb(1, 0);
        aexp = aexp | cb(1, 0);
        chk("t3_solo_known", 128'(known), kexp);
        chk("t3_solo_assign", 128'(assigned), aexp);
        drv(0, 1'b1, 16'd4);
        drv(1, 1'b1, 16'd1);
        cyc();
        drv(0, 1'b1, 16'b010);
        drv(1, 1'b1, 16'b011);
        cyc();
        drv(0, 1'b0, 16'd0);
        drv(1, 1'b0, 16'd0);
        cyc();
        kexp = kexp | cb(1, 1) | cb(1, 2);
        aexp = aexp | cb(1, 1);
        chk("t3_pair2_lane1_first", 128'(known), kexp);
        chk("t3_pair2_assign", 128'(assigned), aexp);
        chk("t3_solved_early", 128'(solved), 128'(0));
        cyc();
        chk("t3_solved", 128'(solved), 128'(1));
        chk("t3_busy", 128'(busy), 128'(0));

        // Push-back backpressure
        init_counts = '0;
        set_cnt(0, 3);
        do_start();
        lif.lane_out_ready[0] = 1'b0;
        drv(0, 1'b1, 16'd0);
        cyc();
        drv(0, 1'b1, 16'b001);
        cyc();
        drv(0, 1'b1, 16'b010);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold", 128'({lif.lane_in_ready[0], lif.lane_out_valid[0], lif.lane_out_data[15:0]}),
                128'({1'b0, 1'b1, 16'h1}));
            cyc();
        end
        lif.lane_out_ready[0] = 1'b1;
        #1;
        chk("t4_release_inrdy", 128'(lif.lane_in_ready[0]), 128'(1));
        cyc();
        chk("t4_beat2", 128'({lif.lane_out_valid[0], lif.lane_out_data[15:0]}), 128'({1'b1, 16'h2}));
        drv(0, 1'b1, 16'b100);
        cyc();
        chk("t4_beat3", 128'({lif.lane_out_valid[0], lif.lane_out_data[15:0]}), 128'({1'b1, 16'h4}));
        drv(0, 1'b0, 16'd0);
        cyc();
        chk("t4_known_none", 128'(known), 128'(0));
        chk("t4_back_header", 128'({lif.lane_in_ready[0], lif.lane_out_valid[0]}), 128'(2'b10));

        // Out-of-range header, then start mid-solve
        init_counts = '0;
        set_cnt(0, 1);
        set_cnt(2, 2);
        set_cnt(9, 1);
        do_start();
        drv(0, 1'b1, 16'd9);
        cyc();
        chk("t5_badhdr_inrdy", 128'(lif.lane_in_ready[0]), 128'(1));
        drv(0, 1'b1, 16'd0);
        cyc();
        drv(0, 1'b1, 16'b001);
        cyc();
        drv(0, 1'b0, 16'd0);
        cyc();
        chk("t5_row0_known", 128'(known), cb(0, 0) | cb(0, 1) | cb(0, 2));
        chk("t5_row0_assign", 128'(assigned), cb(0, 0));
        lif.lane_out_ready[1] = 1'b0;
        drv(1, 1'b1, 16'd2);
        cyc();
        drv(1, 1'b1, 16'b001);
        cyc();
        chk("t5_pending_out", 128'(lif.lane_out_valid[1]), 128'(1));
        drv(1, 1'b0, 16'd0);
        do_start();
        chk("t5_restart_known",  128'(known), 128'(0));
        chk("t5_restart_assign", 128'(assigned), 128'(0));
        chk("t5_restart_solved", 128'(solved), 128'(0));
        chk("t5_restart_busy",   128'(busy), 128'(1));
        chk("t5_restart_inrdy",  128'(lif.lane_in_ready), 128'(2'b11));
        chk("t5_restart_ovalid", 128'(lif.lane_out_valid), 128'(0));
        lif.lane_out_ready[1] = 1'b1;

        // Contradiction: cell(0,0)=1 known, row 0 offers only 0b10
        init_counts = '0;
        set_cnt(0, 1);
        set_cnt(3, 1);
        do_start();
        drv(0, 1'b1, 16'd3);
        cyc();
        drv(0, 1'b1, 16'b001);
        cyc();
        drv(0, 1'b0, 16'd0);
        cyc();
        kexp = cb(0, 0) | cb(1, 0) | cb(2, 0);
        chk("t6_col0_known", 128'(known), kexp);
        chk("t6_col0_assign", 128'(assigned), cb(0, 0));
        drv(0, 1'b1, 16'd0);
        cyc();
        drv(0, 1'b1, 16'b010);
        cyc();
        drv(0, 1'b0, 16'd0);
        cyc();
`ifdef CONFLICT_CHECK_EN
        chk("t6_unsolvable", 128'(unsolvable), 128'(1));
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_known_kept", 128'(known), kexp);
        chk("t6_assign_kept", 128'(assigned), cb(0, 0));
        chk("t6_done_inrdy", 128'(lif.lane_in_ready), 128'(0));
`else
        chk("t6_unsolvable_tied", 128'(unsolvable), 128'(0));
        chk("t6_busy", 128'(busy), 128'(1));
        chk("t6_a1_wins_known", 128'(known), kexp | cb(0, 1) | cb(0, 2));
        chk("t6_a1_wins_assign", 128'(assigned), cb(0, 0) | cb(0, 1) | cb(0, 2));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
